// File: rtl/core_mem_arb_if.sv
// core_mem_arb_if: fetch, data and shared-memory handshake signals of core_mem_arb.
// slave = arbiter view, master = core/memory environment view.
interface core_mem_arb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            i_req;
    logic [AW-1:0]   i_addr;
    logic [DW-1:0]   i_rdata;
    logic            i_ack;
    logic            d_req;
    logic            d_we;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic [DW/8-1:0] d_be;
    logic [DW-1:0]   d_rdata;
    logic            d_ack;
    logic            err;
    logic            m_req;
    logic            m_we;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;
    logic [DW/8-1:0] m_be;
    logic [DW-1:0]   m_rdata;
    logic            m_ack;
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, m_rdata, m_ack,
        output i_rdata, i_ack, d_rdata, d_ack, err, m_req, m_we, m_addr, m_wdata, m_be
    );
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, m_rdata, m_ack,
        input  i_rdata, i_ack, d_rdata, d_ack, err, m_req, m_we, m_addr, m_wdata, m_be
    );
endinterface

// File: rtl/core_mem_arb.sv
// core_mem_arb: shares one single-port memory between fetch and data ports, with ack timeout.
// Define CORE_MEM_ARB_RR_EN for round-robin tie-break; otherwise data always beats fetch.
module core_mem_arb #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int TO_CYCLES = 256
) (
    input logic          i_clk,
    input logic          i_rst_n,
    core_mem_arb_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;
    localparam int CW = TO_CYCLES > 1 ? $clog2(TO_CYCLES) : 1;

    logic [1:0]      r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_m_req;
    logic            r_m_we;
    logic [AW-1:0]   r_m_addr;
    logic [DW-1:0]   r_m_wdata;
    logic [DW/8-1:0] r_m_be;
    logic [DW-1:0]   r_i_rdata;
    logic [DW-1:0]   r_d_rdata;
    logic            r_i_ack;
    logic            r_d_ack;
    logic            r_err;
    logic            w_grant_d;
    logic            w_to;
    logic            w_done;

`ifdef CORE_MEM_ARB_RR_EN
    logic r_last_d;
    assign w_grant_d = bus.d_req & ~(bus.i_req & r_last_d);
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n)
            r_last_d <= 1'b0;
        else if (r_state == IDLE && (bus.d_req || bus.i_req))
            r_last_d <= w_grant_d;
`else
    assign w_grant_d = bus.d_req;
`endif

    // An ack arriving on the expiry cycle wins over the timeout.
    assign w_to   = (TO_CYCLES != 0) && (r_cnt == CW'(TO_CYCLES - 1));
    assign w_done = bus.m_ack | w_to;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_m_req   <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_m_be    <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
            r_i_ack   <= 1'b0;
            r_d_ack   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        r_state   <= BUSY_D;
                        r_m_req   <= 1'b1;
                        r_m_we    <= bus.d_we;
                        r_m_addr  <= bus.d_addr;
                        r_m_wdata <= bus.d_wdata;
                        r_m_be    <= bus.d_we ? bus.d_be : '1;
                    end else if (bus.i_req) begin
                        r_state   <= BUSY_I;
                        r_m_req   <= 1'b1;
                        r_m_we    <= 1'b0;
                        r_m_addr  <= bus.i_addr;
                        r_m_wdata <= '0;
                        r_m_be    <= '1;
                    end
                end
                BUSY_I, BUSY_D: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_done) begin
                        r_state <= DONE;
                        r_m_req <= 1'b0;
                        r_err   <= ~bus.m_ack;
                        if (r_state == BUSY_D) begin
                            r_d_ack   <= 1'b1;
                            r_d_rdata <= bus.m_ack ? bus.m_rdata : '0;
                        end else begin
                            r_i_ack   <= 1'b1;
                            r_i_rdata <= bus.m_ack ? bus.m_rdata : '0;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_i_ack <= 1'b0;
                    r_d_ack <= 1'b0;
                    r_err   <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.m_req   = r_m_req;
    assign bus.m_we    = r_m_we;
    assign bus.m_addr  = r_m_addr;
    assign bus.m_wdata = r_m_wdata;
    assign bus.m_be    = r_m_be;
    assign bus.i_rdata = r_i_rdata;
    assign bus.i_ack   = r_i_ack;
    assign bus.d_rdata = r_d_rdata;
    assign bus.d_ack   = r_d_ack;
    assign bus.err     = r_err;
endmodule

// File: tb/tb_core_mem_arb.sv
// tb_core_mem_arb: vector table, hand sequences and randomized traffic against a reference model.
module tb_core_mem_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    int fixed_delay = 0;
    int m_cnt = 0;
    int mreq_run = 0;
    logic unstable = 1'b0;
    int i_ack_cnt = 0;
    int d_ack_cnt = 0;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

`ifdef CORE_MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    core_mem_arb_if #(.AW(32), .DW(32)) bus ();
    core_mem_arb #(.AW(32), .DW(32), .TO_CYCLES(8)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          delay;
        logic        chk_rd;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          mreq;
    } vec_t;
    vec_t tv [8];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int dly(logic [31:0] a);
        return int'(a[5:2]) % 10;
    endfunction

    function automatic logic [31:0] mem_rd(logic [31:0] a);
        return mem.exists(a) ? mem[a] : ~a;
    endfunction

    function automatic logic [31:0] ref_rd(logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : ~a;
    endfunction

    // Memory device: acks after a chosen number of M_REQ cycles (fixed, or derived from the address).
    always @(negedge clk) begin
        int d;
        logic [31:0] v;
        d = (fixed_delay >= 0) ? fixed_delay : dly(bus.m_addr);
        if (bus.m_req) begin
            bus.m_ack = (m_cnt == d);
            bus.m_rdata = bus.m_ack ? mem_rd(bus.m_addr) : 32'h0;
            if (bus.m_ack && bus.m_we) begin
                v = mem_rd(bus.m_addr);
                for (int b = 0; b < 4; b++)
                    if (bus.m_be[b]) v[8*b +: 8] = bus.m_wdata[8*b +: 8];
                mem[bus.m_addr] = v;
            end
            m_cnt++;
        end else begin
            bus.m_ack = 1'b0;
            m_cnt = 0;
        end
    end

    // Bus monitor: M_REQ length, payload stability, ack pulse width, ERR only with an ack.
    logic prev_req = 1'b0, prev_i = 1'b0, prev_d = 1'b0;
    logic [31:0] s_addr, s_wdata;
    logic [3:0] s_be;
    logic s_we;
    always @(negedge clk) begin
        if (bus.m_req) begin
            if (!prev_req) begin
                mreq_run = 1;
                unstable = 1'b0;
            end else begin
                mreq_run++;
                if (bus.m_addr !== s_addr || bus.m_wdata !== s_wdata || bus.m_be !== s_be || bus.m_we !== s_we)
                    unstable = 1'b1;
            end
            {s_addr, s_wdata, s_be, s_we} = {bus.m_addr, bus.m_wdata, bus.m_be, bus.m_we};
        end
        prev_req = bus.m_req;
        if (bus.i_ack) begin
            i_ack_cnt++;
            chk("i_ack_pulse", {31'b0, prev_i}, 32'h0);
        end
        if (bus.d_ack) begin
            d_ack_cnt++;
            chk("d_ack_pulse", {31'b0, prev_d}, 32'h0);
        end
        if (bus.err) chk("err_with_ack", {31'b0, bus.i_ack | bus.d_ack}, 32'h1);
        prev_i = bus.i_ack;
        prev_d = bus.d_ack;
    end

    task automatic wait_ack(string name, output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!(bus.i_ack || bus.d_ack) && lat < 40);
        if (!(bus.i_ack || bus.d_ack)) chk(name, 32'h0, 32'h1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic run_row(vec_t v, int idx);
        int lat;
        int ic, dc;
        string n;
        n = $sformatf("row%0d", idx);
        ic = i_ack_cnt;
        dc = d_ack_cnt;
        fixed_delay = v.delay;
        if (v.is_d) begin
            {bus.d_we, bus.d_addr, bus.d_wdata, bus.d_be} = {v.we, v.addr, v.wdata, v.be};
            bus.d_req = 1'b1;
        end else begin
            bus.i_addr = v.addr;
            bus.i_req = 1'b1;
        end
        tick();
        chk({n, "_m_req"}, {31'b0, bus.m_req}, 32'h1);
        chk({n, "_m_addr"}, bus.m_addr, v.addr);
        chk({n, "_m_we"}, {31'b0, bus.m_we}, {31'b0, v.is_d & v.we});
        chk({n, "_m_be"}, {28'b0, bus.m_be}, (v.is_d && v.we) ? {28'b0, v.be} : 32'hF);
        if (v.we) chk({n, "_m_wdata"}, bus.m_wdata, v.wdata);
        wait_ack({n, "_ack_timeout"}, lat);
        chk({n, "_lat"}, 32'(lat + 1), 32'(v.lat));
        chk({n, "_own_ack"}, {31'b0, v.is_d ? bus.d_ack : bus.i_ack}, 32'h1);
        chk({n, "_err"}, {31'b0, bus.err}, {31'b0, v.err});
        if (v.chk_rd) chk({n, "_rdata"}, v.is_d ? bus.d_rdata : bus.i_rdata, v.rdata);
        chk({n, "_mreq_len"}, 32'(mreq_run), 32'(v.mreq));
        chk({n, "_stable"}, {31'b0, unstable}, 32'h0);
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        tick();
        chk({n, "_i_cnt"}, 32'(i_ack_cnt), 32'(ic + (v.is_d ? 0 : 1)));
        chk({n, "_d_cnt"}, 32'(d_ack_cnt), 32'(dc + (v.is_d ? 1 : 0)));
    endtask

    task automatic fetch_agent(int n);
        for (int k = 0; k < n; k++) begin
            logic [31:0] a;
            int w;
            logic e_err;
            a = 32'h800 + 32'($urandom_range(0, 255)) * 4;
            bus.i_addr = a;
            bus.i_req = 1'b1;
            w = 0;
            do begin
                tick();
                w++;
            end while (!bus.i_ack && w < 60);
            chk("rnd_i_ack", {31'b0, bus.i_ack}, 32'h1);
            bus.i_req = 1'b0;
            if (bus.i_ack) begin
                e_err = dly(a) >= 8;
                chk("rnd_i_err", {31'b0, bus.err}, {31'b0, e_err});
                chk("rnd_i_rdata", bus.i_rdata, e_err ? 32'h0 : ~a);
            end
            repeat ($urandom_range(0, 3)) tick();
        end
    endtask

    task automatic data_agent(int n);
        for (int k = 0; k < n; k++) begin
            logic [31:0] a, wd, v;
            logic [3:0] be;
            logic we, e_err;
            int w;
            a = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
            we = 1'($urandom_range(0, 1));
            wd = $urandom;
            be = 4'($urandom_range(1, 15));
            {bus.d_we, bus.d_addr, bus.d_wdata, bus.d_be} = {we, a, wd, be};
            bus.d_req = 1'b1;
            w = 0;
            do begin
                tick();
                w++;
            end while (!bus.d_ack && w < 60);
            chk("rnd_d_ack", {31'b0, bus.d_ack}, 32'h1);
            bus.d_req = 1'b0;
            if (bus.d_ack) begin
                e_err = dly(a) >= 8;
                chk("rnd_d_err", {31'b0, bus.err}, {31'b0, e_err});
                if (e_err) chk("rnd_d_rdata_to", bus.d_rdata, 32'h0);
                else if (we) begin
                    v = ref_rd(a);
                    for (int b = 0; b < 4; b++)
                        if (be[b]) v[8*b +: 8] = wd[8*b +: 8];
                    ref_mem[a] = v;
                end else chk("rnd_d_rdata", bus.d_rdata, ref_rd(a));
            end
            repeat ($urandom_range(0, 3)) tick();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int lat, cnt0;
        logic [31:0] e;
        bus.i_req = 1'b0;
        bus.i_addr = '0;
        bus.d_req = 1'b0;
        bus.d_we = 1'b0;
        bus.d_addr = '0;
        bus.d_wdata = '0;
        bus.d_be = '0;
        mem[32'h10] = 32'h0000_0013;
        tv[0] = '{1'b0, 1'b0, 32'h10,  32'h0,        4'hF,    0,    1'b1, 32'h0000_0013, 1'b0, 2, 1};
        tv[1] = '{1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 4'b0011, 4,    1'b0, 32'h0,         1'b0, 6, 5};
        tv[2] = '{1'b1, 1'b0, 32'h200, 32'h0,        4'b0011, 1,    1'b1, 32'hFFFF_BEEF, 1'b0, 3, 2};
        tv[3] = '{1'b0, 1'b0, 32'h20,  32'h0,        4'hF,    7,    1'b1, 32'hFFFF_FFDF, 1'b0, 9, 8};
        tv[4] = '{1'b1, 1'b0, 32'h300, 32'h0,        4'hF,    1000, 1'b1, 32'h0,         1'b1, 9, 8};
        tv[5] = '{1'b0, 1'b0, 32'h10,  32'h0,        4'hF,    2,    1'b1, 32'h0000_0013, 1'b0, 4, 3};
        tv[6] = '{1'b1, 1'b1, 32'h200, 32'hCAFEF00D, 4'b1100, 0,    1'b0, 32'h0,         1'b0, 2, 1};
        tv[7] = '{1'b1, 1'b0, 32'h200, 32'h0,        4'hF,    0,    1'b1, 32'hCAFE_BEEF, 1'b0, 2, 1};

        tick();
        tick();
        chk("rst_m_req", {31'b0, bus.m_req}, 32'h0);
        chk("rst_acks", {30'b0, bus.i_ack, bus.d_ack}, 32'h0);
        chk("rst_err", {31'b0, bus.err}, 32'h0);
        chk("rst_m_addr", bus.m_addr, 32'h0);
        chk("rst_m_be", {28'b0, bus.m_be}, 32'h0);
        chk("rst_rdata", bus.i_rdata | bus.d_rdata, 32'h0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) run_row(tv[i], i);

        // Simultaneous requests from a fresh reset.
        do_reset();
        fixed_delay = 0;
        bus.i_addr = 32'h40;
        bus.d_addr = 32'h400;
        bus.d_we = 1'b0;
        bus.i_req = 1'b1;
        bus.d_req = 1'b1;
        wait_ack("sim1_timeout", lat);
        chk("sim1_d_first", {30'b0, bus.d_ack, bus.i_ack}, 32'h2);
        e = ~32'h400;
        chk("sim1_rdata", bus.d_rdata, e);
        bus.d_req = 1'b0;
        wait_ack("sim2_timeout", lat);
        chk("sim2_fetch", {30'b0, bus.d_ack, bus.i_ack}, 32'h1);
        e = ~32'h40;
        chk("sim2_rdata", bus.i_rdata, e);
        bus.i_req = 1'b0;
        tick();
        bus.i_req = 1'b1;
        bus.d_req = 1'b1;
        wait_ack("sim3_timeout", lat);
        chk("sim3_d", {30'b0, bus.d_ack, bus.i_ack}, 32'h2);
        wait_ack("sim4_timeout", lat);
        chk("sim4_winner", {30'b0, bus.d_ack, bus.i_ack}, RR ? 32'h1 : 32'h2);
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        tick();

        // Reset while a fetch is waiting on memory.
        fixed_delay = 1000;
        bus.i_addr = 32'h44;
        bus.i_req = 1'b1;
        repeat (4) tick();
        chk("mid_busy_m_req", {31'b0, bus.m_req}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_m_req", {31'b0, bus.m_req}, 32'h0);
        bus.i_req = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        cnt0 = i_ack_cnt;
        repeat (12) tick();
        chk("mid_rst_no_ack", 32'(i_ack_cnt), 32'(cnt0));
        run_row(tv[0], 100);

        // Randomized concurrent traffic.
        do_reset();
        fixed_delay = -1;
        fork
            fetch_agent(40);
            data_agent(40);
        join
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/core_mem_arb.md
Name: core_mem_arb

Overview:
- Shares one single-port backing memory between the core's instruction-fetch port and its data load/store port.
- Owns the memory-side req/ack handshake, latches each granted request, and returns read data and a completion pulse to the winning requester.
- Includes a per-transaction timeout that reports an error when the memory never acknowledges.
- Sits between core_top's fetch/data ports and the shared memory or bus bridge.

Parameters:
- AW, 32, address width of both requester ports and the memory port.
- DW, 32, data width; byte-enable width is DW/8.
- TO_CYCLES, 256, memory acknowledge timeout in cycles; 0 disables the timeout.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  reset, asynchronous, active-low.
- I_REQ  in  1  fetch request; held high with I_ADDR stable until I_ACK.
- I_ADDR  in  AW  fetch address.
- I_RDATA  out  DW  fetch data; valid in the I_ACK cycle.
- I_ACK  out  1  one-cycle completion pulse for fetch.
- D_REQ  in  1  data request; held high with D_* inputs stable until D_ACK.
- D_WE  in  1  1 = store, 0 = load.
- D_ADDR  in  AW  data address.
- D_WDATA  in  DW  store data.
- D_BE  in  DW/8  store byte enables.
- D_RDATA  out  DW  load data; valid in the D_ACK cycle.
- D_ACK  out  1  one-cycle completion pulse for data.
- ERR  out  1  high together with I_ACK or D_ACK when that transaction timed out.
- M_REQ  out  1  memory request; held until M_ACK or timeout.
- M_WE  out  1  memory write.
- M_ADDR  out  AW  memory address.
- M_WDATA  out  DW  memory write data.
- M_BE  out  DW/8  memory byte enables; all ones for fetch and load.
- M_RDATA  in  DW  memory read data; valid in the M_ACK cycle.
- M_ACK  in  1  memory completion; sampled only while M_REQ = 1.

Behaviour:
- Reset values: all outputs 0; state IDLE; timeout counter 0. Reset asserted mid-transaction drops M_REQ at once and discards the transaction; no ACK is issued.
- State machine: IDLE, BUSY_I, BUSY_D, DONE. All outputs are registered.
- IDLE:
  - D_REQ=1 → BUSY_D.
  - Else I_REQ=1 → BUSY_I.
  - Both high → the data port wins (fixed priority, unless ARB_RR_EN is defined).
  - On grant, latch address, WE, WDATA and BE into the M_* registers and set M_REQ=1 in the next cycle. A fetch drives M_WE=0 and M_BE=all ones.
- BUSY_x:
  - Counter increments each cycle.
  - M_ACK=1 → capture M_RDATA into x_RDATA, pulse x_ACK=1 and ERR=0 in the next cycle, drop M_REQ, go to DONE.
  - TO_CYCLES≠0 and counter reaches TO_CYCLES-1 without M_ACK → drop M_REQ, pulse x_ACK=1 with ERR=1 and x_RDATA=0, go to DONE.
  - M_ACK in the same cycle as timeout expiry → treated as success (ERR=0).
- DONE:
  - The ACK cycle. No grant is made, because the completed requester still shows REQ=1.
  - Clear counter, go to IDLE.
- Latency and throughput:
  - Request cycle 0 → M_REQ cycle 1 → with M_ACK in cycle 1, x_ACK in cycle 2.
  - Minimum of 3 cycles per transaction.
- x_RDATA holds its last value between ACKs; for stores, D_RDATA is undefined-but-stable (the captured M_RDATA).
- A requester dropping REQ while its transaction is in flight is a protocol violation; the transaction still completes and the ACK is issued.
- M_* payload is stable for the whole time M_REQ=1.

Optional Feature:
- CORE_MEM_ARB_RR_EN defined: round-robin arbitration. A last-winner register (reset value: fetch) gives the simultaneous-request tie to the port that did not win last.
- Not defined: fixed data-over-fetch priority; no last-winner register exists.

Test Plan:
- Fetch only: I_REQ=1, I_ADDR=0x10; memory ACKs in the first M_REQ cycle with M_RDATA=0x00000013 → M_REQ in cycle 1, I_ACK in cycle 2, I_RDATA=0x00000013, ERR=0.
- Store: D_REQ=1, D_WE=1, D_ADDR=0x200, D_WDATA=0xDEADBEEF, D_BE=0b0011; memory ACKs after 4 cycles → M_* carries exactly those values throughout; D_ACK pulses once; I_ACK stays 0.
- Simultaneous: I_REQ and D_REQ both high, held for two transactions → fixed priority: data, fetch. Round-robin with fresh reset: data, fetch, then data again when both are re-asserted.
- Timeout: TO_CYCLES=8, memory never ACKs → M_REQ high for exactly 8 cycles, then D_ACK=1 with ERR=1 and D_RDATA=0; next request proceeds normally.
- Reset mid-operation: RST_N low while in BUSY_I → M_REQ=0 immediately (asynchronous); no I_ACK after release; a fresh fetch completes correctly.
